// File: rtl/apb4_csr_pkg.sv
// Shared types, limits and helpers for the APB4 CSR register bank.
// get_reg is meant for elaboration-time slicing of flattened parameters.
package apb4_csr_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb4_csr_state_e;

    localparam int MAX_WAIT_STATES = 15;
    localparam int CNT_WIDTH       = 4;

    // Upper bounds for get_reg: one register up to 256 bits, the whole bank up to 8192 bits.
    localparam int MAX_DATA_WIDTH  = 256;
    localparam int MAX_FLAT_WIDTH  = 8192;

    function automatic logic [MAX_DATA_WIDTH-1:0] get_reg(
        input logic [MAX_FLAT_WIDTH-1:0] vec,
        input int                        idx,
        input int                        width
    );
        logic [MAX_DATA_WIDTH-1:0] r;
        r = MAX_DATA_WIDTH'(vec >> (idx * width));
        r = r & ~({MAX_DATA_WIDTH{1'b1}} << width);
        return r;
    endfunction

endpackage

// File: rtl/apb4_slave_fsm.sv
// APB4 handshake engine: IDLE/ACCESS state, wait-state counter, latched request,
// pready/pslverr generation and a single-cycle commit strobe for the register bank.
module apb4_slave_fsm
    import apb4_csr_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 3,
    parameter int NUM_REGS    = 8,
    parameter int WAIT_STATES = 0,
    parameter bit PRIV_ONLY   = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    input  logic                    priv,
    output logic                    pready,
    output logic                    pslverr,
    output logic                    commit,
    output logic                    rd_en,
    output logic [ADDR_WIDTH-1:0]   addr_q,
    output logic [DATA_WIDTH-1:0]   wdata_q,
    output logic [DATA_WIDTH/8-1:0] strb_q,
    output apb4_csr_state_e         state
);

    localparam logic [CNT_WIDTH-1:0] WAIT_CNT = CNT_WIDTH'(WAIT_STATES);

    apb4_csr_state_e        state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   latch;
    logic                   wr_q, prot_q;
    logic                   err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            wr_q    <= 1'b0;
            prot_q  <= 1'b0;
        end else begin
            state <= state_d;
            cnt_q <= cnt_d;
            if (latch) begin
                addr_q  <= paddr;
                wdata_q <= pwdata;
                strb_q  <= pstrb;
                wr_q    <= pwrite;
                prot_q  <= priv;
            end
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt_q;
        latch   = 1'b0;
        case (state)
            IDLE: begin
                if (psel && !penable) begin
                    state_d = ACCESS;
                    cnt_d   = '0;
                    latch   = 1'b1;
                end
            end
            ACCESS: begin
                // Dropping psel mid-access abandons the transfer without a commit.
                if (!psel) begin
                    state_d = IDLE;
                end else if (pready) begin
                    state_d = IDLE;
                end else if (penable) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pready  = (state == ACCESS) && psel && penable && (cnt_q == WAIT_CNT);
    assign err     = ({1'b0, addr_q} >= (ADDR_WIDTH + 1)'(NUM_REGS))
                   || (PRIV_ONLY && wr_q && !prot_q);
    assign pslverr = pready && err;
    assign commit  = pready && wr_q && !err;
    assign rd_en   = pready && !wr_q && !err;

endmodule

// File: rtl/apb4_csr_regbank.sv
// Parametrised APB4 CSR bank: masked software-writable bits, live status bits,
// hardware load port with byte-granular priority, and per-register write pulses.
module apb4_csr_regbank
    import apb4_csr_pkg::*;
#(
    parameter int                               DATA_WIDTH  = 32,
    parameter int                               ADDR_WIDTH  = 3,
    parameter int                               NUM_REGS    = 8,
    parameter int                               WAIT_STATES = 0,
    parameter bit                               PRIV_ONLY   = 1'b0,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0]   WR_MASK     = '1,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0]   RESET_VAL   = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           psel,
    input  logic                           penable,
    input  logic                           pwrite,
    input  logic [ADDR_WIDTH-1:0]          paddr,
    input  logic [DATA_WIDTH-1:0]          pwdata,
    input  logic [DATA_WIDTH/8-1:0]        pstrb,
    input  logic [2:0]                     pprot,
    output logic [DATA_WIDTH-1:0]          prdata,
    output logic                           pready,
    output logic                           pslverr,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
    output logic [NUM_REGS-1:0]            wr_pulse_o,
    input  logic [NUM_REGS-1:0]            hw_we_i,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_wdata_i,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_status_i
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic                    commit, rd_en;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q, lane_mask;
    logic [STRB_WIDTH-1:0]   strb_q;
    apb4_csr_state_e         unused_fsm_state;
    logic                    unused_prot;
    logic [DATA_WIDTH-1:0]   rd_or [NUM_REGS+1];

    assign unused_prot = ^pprot[2:1];

    apb4_slave_fsm #(
        .DATA_WIDTH  (DATA_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .NUM_REGS    (NUM_REGS),
        .WAIT_STATES (WAIT_STATES),
        .PRIV_ONLY   (PRIV_ONLY)
    ) u_fsm (
        .clk     (clk),
        .rst     (rst),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .pstrb   (pstrb),
        .priv    (pprot[0]),
        .pready  (pready),
        .pslverr (pslverr),
        .commit  (commit),
        .rd_en   (rd_en),
        .addr_q  (addr_q),
        .wdata_q (wdata_q),
        .strb_q  (strb_q),
        .state   (unused_fsm_state)
    );

    for (genvar b = 0; b < STRB_WIDTH; b++) begin : g_lane
        assign lane_mask[b*8 +: 8] = {8{strb_q[b]}};
    end

    assign rd_or[0] = '0;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        localparam logic [DATA_WIDTH-1:0] MASK =
            DATA_WIDTH'(get_reg(MAX_FLAT_WIDTH'(WR_MASK), i, DATA_WIDTH));
        localparam logic [DATA_WIDTH-1:0] RST_VAL =
            DATA_WIDTH'(get_reg(MAX_FLAT_WIDTH'(RESET_VAL), i, DATA_WIDTH));

        logic                  sw_hit, pulse_q;
        logic [DATA_WIDTH-1:0] q, nxt, sw_bits;

        assign sw_hit  = commit && (addr_q == ADDR_WIDTH'(i));
        assign sw_bits = lane_mask & MASK;

        // Hardware load first, then software overrides only the strobed, writable bits.
        always_comb begin
            nxt = q;
            if (hw_we_i[i]) begin
                nxt = hw_wdata_i[i*DATA_WIDTH +: DATA_WIDTH] & MASK;
            end
            if (sw_hit) begin
                nxt = (nxt & ~sw_bits) | (wdata_q & sw_bits);
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                q       <= RST_VAL & MASK;
                pulse_q <= 1'b0;
            end else begin
                q       <= nxt;
                pulse_q <= sw_hit;
            end
        end

        assign regs_o[i*DATA_WIDTH +: DATA_WIDTH] = q;
        assign wr_pulse_o[i] = pulse_q;
        assign rd_or[i+1] = rd_or[i]
            | ((rd_en && (addr_q == ADDR_WIDTH'(i)))
               ? ((q & MASK) | (hw_status_i[i*DATA_WIDTH +: DATA_WIDTH] & ~MASK))
               : '0);
    end

    assign prdata = rd_or[NUM_REGS];

endmodule

// File: tb/tb_apb4_csr_regbank.sv
// Self-checking bench for apb4_csr_regbank: 4 x 32-bit registers, two wait states,
// reg0 writable only in its low byte, plus a PRIV_ONLY instance for protection checks.
module tb_apb4_csr_regbank;

    localparam int DW = 32;
    localparam int AW = 3;
    localparam int NR = 4;
    localparam int WS = 2;
    localparam logic [NR*DW-1:0] TB_MASK =
        {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_00FF};

    logic            clk = 1'b0;
    logic            rst;
    logic            psel, psel_p, penable, pwrite;
    logic [AW-1:0]   paddr;
    logic [DW-1:0]   pwdata;
    logic [DW/8-1:0] pstrb;
    logic [2:0]      pprot;
    logic [NR-1:0]   hw_we;
    logic [NR*DW-1:0] hw_wdata, hw_status;

    logic [DW-1:0]    prdata, prdata_p;
    logic             pready, pready_p, pslverr, pslverr_p;
    logic [NR*DW-1:0] regs, regs_p;
    logic [NR-1:0]    wr_pulse, wr_pulse_p;

    int checks = 0;
    int passed = 0;
    logic [DW-1:0] exp_q[$];
    logic          exp_err_q[$];
    logic [DW-1:0] model [NR];

    always #5 clk = ~clk;

    apb4_csr_regbank #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .WAIT_STATES(WS),
        .PRIV_ONLY(1'b0), .WR_MASK(TB_MASK), .RESET_VAL(128'h0)
    ) dut (
        .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .prdata(prdata), .pready(pready), .pslverr(pslverr), .regs_o(regs),
        .wr_pulse_o(wr_pulse), .hw_we_i(hw_we), .hw_wdata_i(hw_wdata),
        .hw_status_i(hw_status)
    );

    apb4_csr_regbank #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .WAIT_STATES(WS),
        .PRIV_ONLY(1'b1), .WR_MASK(TB_MASK), .RESET_VAL(128'h0)
    ) dut_p (
        .clk(clk), .rst(rst), .psel(psel_p), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .prdata(prdata_p), .pready(pready_p), .pslverr(pslverr_p), .regs_o(regs_p),
        .wr_pulse_o(wr_pulse_p), .hw_we_i(hw_we), .hw_wdata_i(hw_wdata),
        .hw_status_i(hw_status)
    );

    function automatic logic [DW-1:0] wmask(int i);
        return (i == 0) ? 32'h0000_00FF : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [DW-1:0] apply_wr(logic [DW-1:0] old, logic [DW-1:0] d,
                                              logic [3:0] s, logic [DW-1:0] m);
        logic [DW-1:0] bm;
        for (int b = 0; b < 4; b++) bm[b*8 +: 8] = {8{s[b]}};
        bm = bm & m;
        return (old & ~bm) | (d & bm);
    endfunction

    function automatic logic [DW-1:0] rd_exp(int i);
        return (model[i] & wmask(i)) | (hw_status[i*DW +: DW] & ~wmask(i));
    endfunction

    function automatic logic [NR*DW-1:0] model_flat();
        return {model[3], model[2], model[1], model[0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one transfer starting at posedge+1; scoreboard entry is popped when pready shows.
    task automatic apb_xfer(input string tag, input bit on_p, input logic [AW-1:0] a,
                            input bit wr, input logic [DW-1:0] d, input logic [3:0] s,
                            input logic [2:0] prot, input logic [NR-1:0] hw_at_ready,
                            output int waited);
        logic [DW-1:0] rdata, exp_d;
        logic          err, exp_e;
        bit            done;
        psel = !on_p; psel_p = on_p; penable = 1'b0; pwrite = wr;
        paddr = a; pwdata = d; pstrb = s; pprot = prot;
        tick();
        penable = 1'b1;
        waited = 0;
        done = 1'b0;
        while (!done && waited <= 20) begin
            @(negedge clk);
            if ((on_p ? pready_p : pready) === 1'b1) begin
                done  = 1'b1;
                rdata = on_p ? prdata_p : prdata;
                err   = on_p ? pslverr_p : pslverr;
                hw_we = hw_at_ready;
            end else begin
                waited++;
            end
        end
        exp_d = exp_q.pop_front();
        exp_e = exp_err_q.pop_front();
        checks++;
        if (!done) begin
            $display("FAIL %s: pready not seen within %0d cycles", tag, waited);
        end else if (rdata !== exp_d || err !== exp_e) begin
            $display("FAIL %s: prdata=%h pslverr=%b, expected prdata=%h pslverr=%b",
                     tag, rdata, err, exp_d, exp_e);
        end else begin
            passed++;
        end
        tick();
        psel = 1'b0; psel_p = 1'b0; penable = 1'b0; hw_we = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks += 6;
        if (pready !== 1'b0) $display("FAIL reset_pready: got %b want 0", pready); else passed++;
        if (pslverr !== 1'b0) $display("FAIL reset_pslverr: got %b want 0", pslverr); else passed++;
        if (prdata !== '0) $display("FAIL reset_prdata: got %h want 0", prdata); else passed++;
        if (wr_pulse !== '0) $display("FAIL reset_pulse: got %b want 0", wr_pulse); else passed++;
        if (regs !== '0) $display("FAIL reset_regs: got %h want 0", regs); else passed++;
        if (regs_p !== '0) $display("FAIL reset_regs_p: got %h want 0", regs_p); else passed++;
        rst = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = '0;
        tick();
    endtask

    task automatic test_basic_write_read();
        int w;
        exp_q.push_back('0); exp_err_q.push_back(1'b0);
        apb_xfer("basic_wr", 1'b0, 3'd1, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b001, '0, w);
        model[1] = 32'hDEAD_BEEF;
        checks += 3;
        if (w !== WS) $display("FAIL basic_latency: waited %0d want %0d", w, WS); else passed++;
        if (regs[1*DW +: DW] !== 32'hDEAD_BEEF)
            $display("FAIL basic_regs: got %h want deadbeef", regs[1*DW +: DW]);
        else passed++;
        if (wr_pulse !== 4'b0010) $display("FAIL basic_pulse: got %b want 0010", wr_pulse); else passed++;
        tick();
        checks++;
        if (wr_pulse !== 4'b0000) $display("FAIL basic_pulse_end: got %b want 0000", wr_pulse); else passed++;
        exp_q.push_back(32'hDEAD_BEEF); exp_err_q.push_back(1'b0);
        apb_xfer("basic_rd", 1'b0, 3'd1, 1'b0, '0, 4'h0, 3'b001, '0, w);
    endtask

    task automatic test_byte_strobes();
        int w;
        exp_q.push_back('0); exp_err_q.push_back(1'b0);
        apb_xfer("strb_pre", 1'b0, 3'd2, 1'b1, 32'hFFFF_FFFF, 4'hF, 3'b001, '0, w);
        exp_q.push_back('0); exp_err_q.push_back(1'b0);
        apb_xfer("strb_wr", 1'b0, 3'd2, 1'b1, 32'h1122_3344, 4'b0101, 3'b001, '0, w);
        model[2] = 32'hFF22_FF44;
        checks++;
        if (regs[2*DW +: DW] !== 32'hFF22_FF44)
            $display("FAIL strb_regs: got %h want ff22ff44", regs[2*DW +: DW]);
        else passed++;
        exp_q.push_back('0); exp_err_q.push_back(1'b0);
        apb_xfer("strb_zero", 1'b0, 3'd2, 1'b1, 32'h0000_0000, 4'b0000, 3'b001, '0, w);
        checks += 2;
        if (wr_pulse !== 4'b0100) $display("FAIL strb_zero_pulse: got %b want 0100", wr_pulse); else passed++;
        if (regs[2*DW +: DW] !== 32'hFF22_FF44)
            $display("FAIL strb_zero_regs: got %h want ff22ff44", regs[2*DW +: DW]);
        else passed++;
        exp_q.push_back(32'hFF22_FF44); exp_err_q.push_back(1'b0);
        apb_xfer("strb_rd", 1'b0, 3'd2, 1'b0, '0, 4'h0, 3'b001, '0, w);
    endtask

    task automatic test_mask_status();
        int w;
        hw_status[0 +: DW] = 32'hABCD_0000;
        exp_q.push_back('0); exp_err_q.push_back(1'b0);
        apb_xfer("mask_wr", 1'b0, 3'd0, 1'b1, 32'hFFFF_FFFF, 4'hF, 3'b001, '0, w);
        model[0] = 32'h0000_00FF;
        checks++;
        if (regs[0 +: DW] !== 32'h0000_00FF)
            $display("FAIL mask_regs: got %h want 000000ff", regs[0 +: DW]);
        else passed++;
        exp_q.push_back(32'hABCD_00FF); exp_err_q.push_back(1'b0);
        apb_xfer("mask_rd", 1'b0, 3'd0, 1'b0, '0, 4'h0, 3'b001, '0, w);
        hw_status[0 +: DW] = 32'h1234_5600;
        exp_q.push_back(32'h1234_56FF); exp_err_q.push_back(1'b0);
        apb_xfer("status_live", 1'b0, 3'd0, 1'b0, '0, 4'h0, 3'b001, '0, w);
    endtask

    task automatic test_errors();
        int w;
        exp_q.push_back('0); exp_err_q.push_back(1'b1);
        apb_xfer("err_wr_oob", 1'b0, 3'd5, 1'b1, 32'h1234_5678, 4'hF, 3'b001, '0, w);
        checks += 2;
        if (regs !== model_flat()) $display("FAIL err_oob_regs: got %h want %h", regs, model_flat()); else passed++;
        if (wr_pulse !== '0) $display("FAIL err_oob_pulse: got %b want 0000", wr_pulse); else passed++;
        exp_q.push_back('0); exp_err_q.push_back(1'b1);
        apb_xfer("err_rd_oob", 1'b0, 3'd7, 1'b0, '0, 4'h0, 3'b001, '0, w);
        exp_q.push_back('0); exp_err_q.push_back(1'b1);
        apb_xfer("priv_wr_user", 1'b1, 3'd1, 1'b1, 32'hCAFE_F00D, 4'hF, 3'b000, '0, w);
        checks += 2;
        if (regs_p[1*DW +: DW] !== '0) $display("FAIL priv_user_regs: got %h want 0", regs_p[1*DW +: DW]); else passed++;
        if (wr_pulse_p !== '0) $display("FAIL priv_user_pulse: got %b want 0000", wr_pulse_p); else passed++;
        exp_q.push_back('0); exp_err_q.push_back(1'b0);
        apb_xfer("priv_wr_ok", 1'b1, 3'd1, 1'b1, 32'hCAFE_F00D, 4'hF, 3'b001, '0, w);
        checks++;
        if (regs_p[1*DW +: DW] !== 32'hCAFE_F00D)
            $display("FAIL priv_ok_regs: got %h want cafef00d", regs_p[1*DW +: DW]);
        else passed++;
        exp_q.push_back(32'hCAFE_F00D); exp_err_q.push_back(1'b0);
        apb_xfer("priv_rd_user", 1'b1, 3'd1, 1'b0, '0, 4'h0, 3'b000, '0, w);
    endtask

    task automatic test_collision();
        int w;
        hw_wdata[3*DW +: DW] = 32'h5555_5555;
        exp_q.push_back('0); exp_err_q.push_back(1'b0);
        apb_xfer("coll_wr", 1'b0, 3'd3, 1'b1, 32'h0000_AAAA, 4'b0011, 3'b001, 4'b1000, w);
        model[3] = 32'h5555_AAAA;
        checks += 2;
        if (regs[3*DW +: DW] !== 32'h5555_AAAA)
            $display("FAIL coll_regs: got %h want 5555aaaa", regs[3*DW +: DW]);
        else passed++;
        if (wr_pulse !== 4'b1000) $display("FAIL coll_pulse: got %b want 1000", wr_pulse); else passed++;
        hw_wdata[0 +: DW] = 32'h1234_5678;
        hw_we = 4'b0001;
        tick();
        hw_we = '0;
        model[0] = 32'h0000_0078;
        checks += 2;
        if (regs[0 +: DW] !== 32'h0000_0078) $display("FAIL hw_load_regs: got %h want 00000078", regs[0 +: DW]); else passed++;
        if (wr_pulse !== '0) $display("FAIL hw_load_pulse: got %b want 0000", wr_pulse); else passed++;
    endtask

    task automatic test_random();
        int w, r;
        logic [DW-1:0] d;
        logic [3:0] s;
        for (int n = 0; n < 8; n++) begin
            r = $urandom_range(0, NR - 1);
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            exp_q.push_back('0); exp_err_q.push_back(1'b0);
            apb_xfer("rand_wr", 1'b0, AW'(r), 1'b1, d, s, 3'b001, '0, w);
            model[r] = apply_wr(model[r], d, s, wmask(r));
            checks++;
            if (regs[r*DW +: DW] !== model[r])
                $display("FAIL rand_regs: reg%0d got %h want %h", r, regs[r*DW +: DW], model[r]);
            else passed++;
            exp_q.push_back(rd_exp(r)); exp_err_q.push_back(1'b0);
            apb_xfer("rand_rd", 1'b0, AW'(r), 1'b0, '0, 4'h0, 3'b001, '0, w);
        end
    endtask

    task automatic test_back_to_back();
        int w;
        exp_q.push_back('0); exp_err_q.push_back(1'b0);
        apb_xfer("b2b_wr1", 1'b0, 3'd1, 1'b1, 32'h0F0F_0F0F, 4'hF, 3'b001, '0, w);
        model[1] = 32'h0F0F_0F0F;
        checks++;
        if (wr_pulse !== 4'b0010) $display("FAIL b2b_pulse1: got %b want 0010", wr_pulse); else passed++;
        exp_q.push_back('0); exp_err_q.push_back(1'b0);
        apb_xfer("b2b_wr3", 1'b0, 3'd3, 1'b1, 32'hA5A5_5A5A, 4'hF, 3'b001, '0, w);
        model[3] = 32'hA5A5_5A5A;
        checks += 2;
        if (w !== WS) $display("FAIL b2b_latency: waited %0d want %0d", w, WS); else passed++;
        if (wr_pulse !== 4'b1000) $display("FAIL b2b_pulse3: got %b want 1000", wr_pulse); else passed++;
        exp_q.push_back(32'h0F0F_0F0F); exp_err_q.push_back(1'b0);
        apb_xfer("b2b_rd1", 1'b0, 3'd1, 1'b0, '0, 4'h0, 3'b001, '0, w);
        exp_q.push_back(32'hA5A5_5A5A); exp_err_q.push_back(1'b0);
        apb_xfer("b2b_rd3", 1'b0, 3'd3, 1'b0, '0, 4'h0, 3'b001, '0, w);
        checks++;
        if (w !== WS) $display("FAIL b2b_rd_latency: waited %0d want %0d", w, WS); else passed++;
    endtask

    task automatic test_abort();
        int w;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 3'd1;
        pwdata = 32'h0BAD_0BAD; pstrb = 4'hF; pprot = 3'b001;
        tick();
        penable = 1'b1;
        tick();
        psel = 1'b0; penable = 1'b0;
        tick();
        checks += 2;
        if (wr_pulse !== '0) $display("FAIL abort_pulse: got %b want 0000", wr_pulse); else passed++;
        if (regs !== model_flat()) $display("FAIL abort_regs: got %h want %h", regs, model_flat()); else passed++;
        exp_q.push_back(model[1]); exp_err_q.push_back(1'b0);
        apb_xfer("abort_rd", 1'b0, 3'd1, 1'b0, '0, 4'h0, 3'b001, '0, w);
        checks++;
        if (w !== WS) $display("FAIL abort_latency: waited %0d want %0d", w, WS); else passed++;
    endtask

    task automatic test_reset_mid();
        int w;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 3'd2;
        pwdata = 32'h7777_7777; pstrb = 4'hF; pprot = 3'b001;
        tick();
        penable = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        checks += 5;
        if (pready !== 1'b0) $display("FAIL rstmid_pready: got %b want 0", pready); else passed++;
        if (pslverr !== 1'b0) $display("FAIL rstmid_pslverr: got %b want 0", pslverr); else passed++;
        if (prdata !== '0) $display("FAIL rstmid_prdata: got %h want 0", prdata); else passed++;
        if (wr_pulse !== '0) $display("FAIL rstmid_pulse: got %b want 0", wr_pulse); else passed++;
        if (regs !== '0) $display("FAIL rstmid_regs: got %h want 0", regs); else passed++;
        rst = 1'b0; psel = 1'b0; penable = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = '0;
        tick();
        exp_q.push_back('0); exp_err_q.push_back(1'b0);
        apb_xfer("post_rst_wr", 1'b0, 3'd2, 1'b1, 32'h1357_9BDF, 4'hF, 3'b001, '0, w);
        model[2] = 32'h1357_9BDF;
        checks++;
        if (regs[2*DW +: DW] !== 32'h1357_9BDF)
            $display("FAIL post_rst_regs: got %h want 13579bdf", regs[2*DW +: DW]);
        else passed++;
        exp_q.push_back(32'h1357_9BDF); exp_err_q.push_back(1'b0);
        apb_xfer("post_rst_rd", 1'b0, 3'd2, 1'b0, '0, 4'h0, 3'b001, '0, w);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; psel = 1'b0; psel_p = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; pprot = '0; hw_we = '0; hw_wdata = '0;
        hw_status = {$urandom, $urandom, $urandom, 32'hABCD_0000};
        test_reset();
        test_basic_write_read();
        test_byte_strobes();
        test_mask_status();
        test_errors();
        test_collision();
        test_random();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
